eco32f_wb_ram: RTL
==================

// Module: eco32f_wb_ram
// PURPOSE
//  Wishbone B3 slave: single-port on-chip RAM; target of the data-side LSU master.
//  Serves classic single-beat reads and writes with big-endian byte lanes.
//  Serves registered-feedback incrementing/wrapping bursts, e.g. the 8-beat wrapped
//  cache-line refill (cti=010, bte=10, closed by cti=111).
//  Decodes its own address window and answers err outside it.
// PARAMETERS
//  AW           14            word-index bits; RAM is 2^AW 32-bit words
//  BASE_ADDR    32'h0000_0000 window base; window = BASE_ADDR[31:AW+2] match
//  WAIT_STATES  0             extra cycles before the FIRST ack of each cycle/burst (0..15)
// PORTS
//  clk        in   1   clock
//  rst        in   1   synchronous reset, active-high
//  wbs_adr_i  in   32  byte address; [1:0] ignored
//  wbs_dat_i  in   32  write data
//  wbs_sel_i  in   4   byte lanes; sel[3]=bits 31:24=lowest byte address
//  wbs_we_i   in   1   1=write
//  wbs_stb_i  in   1   strobe
//  wbs_cyc_i  in   1   cycle valid
//  wbs_cti_i  in   3   000/001 classic, 010 incrementing burst, 111 end of burst
//  wbs_bte_i  in   2   00 linear, 01 4-beat wrap, 10 8-beat wrap, 11 16-beat wrap
//  wbs_dat_o  out  32  read data; valid while wbs_ack_o=1
//  wbs_ack_o  out  1   beat done (registered)
//  wbs_err_o  out  1   address outside window (registered)
//  wbs_rty_o  out  1   tied 0
// BEHAVIOUR
//  Reset: ack_o=0, err_o=0, dat_o=0, state=IDLE. RAM contents are not reset.
//  req = cyc_i & stb_i. Beat completes on a rising edge with req & ack_o.
//  All outputs are registered. The RAM is read synchronously.
//  States:
//   IDLE: on req, latch adr[AW+1:2] into badr.
//    - Out of window: err_o=1 for exactly 1 cycle, back to IDLE. No RAM access, no ack.
//    - In window: go to WAIT if WAIT_STATES>0; otherwise ack_o=1 the next cycle and
//      enter BEAT.
//   WAIT: count down WAIT_STATES cycles, then ack_o=1 and enter BEAT.
//    - Read latency at WAIT_STATES=0 is 1 cycle, req to ack.
//   BEAT (ack_o=1):
//    - Write: on the completing edge, write only the bytes whose sel bit is set.
//    - Classic (cti!=010), or cti=111: the next cycle has ack_o=0 and the state is
//      IDLE. A classic master therefore sees ack for 1 cycle and at least 1 idle cycle
//      between beats.
//    - cti=010: badr advances to the next address, ack_o stays 1, and the next beat's
//      data is on dat_o the next cycle. Burst beats are back-to-back with no wait
//      states.
//  Burst address: nxt[1:0]=0.
//    - bte=00: badr+1, full AW-bit wrap.
//    - bte=01: wraps within word-index bit [1:0] (4 words).
//    - bte=10: wraps within word-index bits [2:0] (8 words).
//    - bte=11: wraps within word-index bits [3:0] (16 words).
//    - The bits above the wrap field stay constant.
//  Burst crossing out of the window: impossible with wraps. Linear bursts wrap
//  modulo 2^AW; no err.
//  The RAM read address mux is nxt when (ack_o & req & cti==010), else wbs_adr_i.
//  This makes data for beat n+1 present with the ack of beat n+1.
//  Abort: if req drops while in WAIT or BEAT, then ack_o=0 the next cycle, the state
//  is IDLE, and no write happens on that edge.
//  Reset mid-burst: ack_o=0 and err_o=0 the next cycle. A write coinciding with rst=1
//  is suppressed.
//  err_o and ack_o are never both 1. rty_o is constant 0.
// TESTING
//  T1 classic read: RAM[0x10]=0x11223344; read adr 0x10, sel 1111
//     -> ack 1 cycle after stb, dat_o=0x11223344, ack low the next cycle.
//  T2 byte write: RAM[0x20]=0xAABBCCDD; write adr 0x21, sel 0100, dat 0x00550000,
//     then read -> 0xAA55CCDD.
//  T3 wrap burst: RAM[i]=i*4 for words 0..7; cti=010, bte=10, start adr 0x14,
//     master increments adr per ack, cti=111 on the 8th beat
//     -> 8 consecutive acks, data 0x14,0x18,0x1C,0x00,0x04,0x08,0x0C,0x10,
//        ack=0 after beat 8.
//  T4 out of window (BASE_ADDR=0, AW=14): read adr 0x0001_0000
//     -> err_o=1 for 1 cycle, ack_o never 1, RAM unchanged.
//  T5 abort/reset: drop cyc after beat 3 of a wrap burst -> ack=0 the next cycle.
//     Repeat with rst at beat 3 -> ack=0, err=0 the next cycle; a follow-up classic
//     read works.
//  T6 WAIT_STATES=3: classic read -> ack exactly 4 cycles after stb.
//     Burst -> first ack at +4, then 1 ack per cycle.

Source files
------------

// File: rtl/eco32f_wb_ram.sv
// eco32f_wb_ram: Wishbone B3 single-port RAM slave with big-endian lanes
// and registered-feedback incrementing/wrapping bursts.
module eco32f_wb_ram #(
    parameter int unsigned AW          = 14,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic [2:0]  wbs_cti_i,
    input  logic [1:0]  wbs_bte_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        wbs_rty_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BEAT
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] badr_q, badr_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [31:0]   dat_q;
    logic [31:0]   mem_q [0:(2**AW)-1];

    logic          req;
    logic          in_win;
    logic          burst;
    logic          step;
    logic          wr_en;
    logic [AW-1:0] wmask;
    logic [AW-1:0] nxt;
    logic [AW-1:0] rd_adr;
    logic          unused_adr;

    assign req        = wbs_cyc_i & wbs_stb_i;
    assign in_win     = wbs_adr_i[31:AW+2] == BASE_ADDR[31:AW+2];
    assign burst      = wbs_cti_i == 3'b010;
    assign unused_adr = ^wbs_adr_i[1:0];

    always_comb begin
        wmask = '1;
        unique case (wbs_bte_i)
            2'b00: wmask = '1;
            2'b01: wmask = AW'(4'h3);
            2'b10: wmask = AW'(4'h7);
            2'b11: wmask = AW'(4'hF);
        endcase
    end

    // Bits above the wrap field hold; bits inside it increment modulo the wrap.
    assign nxt    = (badr_q & ~wmask) | ((badr_q + AW'(1)) & wmask);
    assign step   = ack_q & req & burst;
    assign rd_adr = step ? nxt : wbs_adr_i[AW+1:2];
    assign wr_en  = (state_q == S_BEAT) & req & wbs_we_i & ~rst;

    always_comb begin
        state_d = state_q;
        badr_d  = badr_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // A request still held during its own err cycle is not re-decoded.
                if (req && !err_q) begin
                    badr_d = wbs_adr_i[AW+1:2];
                    if (!in_win) begin
                        err_d = 1'b1;
                    end else if (WAIT_STATES == 0) begin
                        ack_d   = 1'b1;
                        state_d = S_BEAT;
                    end else begin
                        cnt_d   = 4'(WAIT_STATES - 1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    ack_d   = 1'b1;
                    state_d = S_BEAT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_BEAT: begin
                if (req && burst) begin
                    badr_d = nxt;
                    ack_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            badr_q  <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            badr_q  <= badr_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= mem_q[rd_adr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wbs_sel_i[i]) begin
                    mem_q[badr_q][8*i +: 8] <= wbs_dat_i[8*i +: 8];
                end
            end
        end
    end

    assign wbs_dat_o = dat_q;
    assign wbs_ack_o = ack_q;
    assign wbs_err_o = err_q;
    assign wbs_rty_o = 1'b0;

endmodule
